// File: rtl/seu_monitor_pkg.sv
// rtl/seu_monitor_pkg.sv - shared types and helpers for the SEU correction-event monitor
package seu_monitor_pkg;

    // Readout handshake: one accepted request produces exactly one response cycle
    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } rd_state_t;

    // Widest counter the helpers support; narrower counters are zero-extended into it
    localparam int unsigned MAX_CNT_W = 32;

    typedef logic [MAX_CNT_W-1:0] cnt_word_t;

    // All-ones value of a w-bit counter, expressed in the wide word
    function automatic cnt_word_t cnt_max(input int unsigned w);
        cnt_word_t m;
        if (w >= MAX_CNT_W) begin
            m = '1;
        end else begin
            m = (cnt_word_t'(1) << w) - cnt_word_t'(1);
        end
        return m;
    endfunction

    // Increment that sticks at the w-bit ceiling instead of wrapping
    function automatic cnt_word_t sat_inc(input cnt_word_t v, input int unsigned w);
        return (v >= cnt_max(w)) ? v : v + cnt_word_t'(1);
    endfunction

    // Select width for n sources, never narrower than one bit
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? int'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/seu_event_counter.sv
// rtl/seu_event_counter.sv - per-source edge detect, saturating event counter and stuck timer
module seu_event_counter
    import seu_monitor_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int STUCK_CYC = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             i_sec,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_stuck
);

    localparam int TMR_W = $clog2(STUCK_CYC + 1);

    logic             r_sec_prev;
    logic             r_evt;
    logic [CNT_W-1:0] r_cnt;
    logic [TMR_W-1:0] r_tmr;
    logic             r_stuck;

    cnt_word_t        w_inc;
    logic [TMR_W-1:0] w_tmr_next;

    assign w_inc = sat_inc(cnt_word_t'(r_cnt), CNT_W);

    // Stuck timer: counts consecutive high samples, parks at STUCK_CYC, zeroes on any low sample
    always_comb begin
        w_tmr_next = '0;
        if (i_sec) begin
            w_tmr_next = (r_tmr == TMR_W'(STUCK_CYC)) ? r_tmr : r_tmr + TMR_W'(1);
        end
    end

    // Edge register feeds a one-cycle event strobe; a clear coinciding with an event keeps that event
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_sec_prev <= 1'b0;
            r_evt      <= 1'b0;
            r_cnt      <= '0;
            r_tmr      <= '0;
            r_stuck    <= 1'b0;
        end else begin
            r_sec_prev <= i_sec;
            r_evt      <= i_sec & ~r_sec_prev;
            if (i_clr) begin
                r_cnt <= r_evt ? CNT_W'(1) : '0;
            end else if (r_evt) begin
                r_cnt <= w_inc[CNT_W-1:0];
            end
            r_tmr   <= w_tmr_next;
            r_stuck <= (w_tmr_next == TMR_W'(STUCK_CYC));
        end
    end

    assign o_cnt   = r_cnt;
    assign o_stuck = r_stuck;

endmodule

// File: rtl/hamming_seu_monitor.sv
// rtl/hamming_seu_monitor.sv - correction-event statistics, stuck detection and readout for FSM correctors
module hamming_seu_monitor
    import seu_monitor_pkg::*;
#(
    parameter  int NUM_SRC   = 4,
    parameter  int CNT_W     = 16,
    parameter  int THRESH    = 100,
    parameter  int STUCK_CYC = 8,
    localparam int SEL_W     = sel_width(NUM_SRC)
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [NUM_SRC-1:0] sec_i,
    input  logic               rd_req_i,
    input  logic [SEL_W-1:0]   rd_sel_i,
    input  logic               rd_clr_i,
    output logic               rd_valid_o,
    output logic [CNT_W-1:0]   rd_cnt_o,
    output logic               rd_stuck_o,
    output logic [NUM_SRC-1:0] stuck_o,
    output logic               irq_o,
    input  logic               irq_ack_i
);

    logic [CNT_W-1:0]   w_cnt [NUM_SRC];
    logic [NUM_SRC-1:0] w_stuck;
    logic [NUM_SRC-1:0] w_clr;
    logic               w_accept;
    logic [CNT_W-1:0]   w_sel_cnt;
    logic               w_sel_stuck;
    logic               w_over;

    rd_state_t          r_state;
    logic               r_valid;
    logic [CNT_W-1:0]   r_rd_cnt;
    logic               r_rd_stuck;
    logic               r_irq;

    // Requests arriving while a response is on the port are dropped
    assign w_accept = (r_state == IDLE) && rd_req_i;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        // An out-of-range select matches no source, so its clear goes nowhere
        assign w_clr[g] = w_accept && rd_clr_i && (rd_sel_i == SEL_W'(g));

        seu_event_counter #(
            .CNT_W     (CNT_W),
            .STUCK_CYC (STUCK_CYC)
        ) u_cnt (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .i_sec   (sec_i[g]),
            .i_clr   (w_clr[g]),
            .o_cnt   (w_cnt[g]),
            .o_stuck (w_stuck[g])
        );
    end

    // Select mux reads the registered counters, i.e. the value before this cycle's update or clear
    always_comb begin
        w_sel_cnt   = '0;
        w_sel_stuck = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (rd_sel_i == SEL_W'(i)) begin
                w_sel_cnt   = w_cnt[i];
                w_sel_stuck = w_stuck[i];
            end
        end
    end

    // Threshold compare in the wide word so a THRESH above the counter ceiling never fires
    always_comb begin
        w_over = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (cnt_word_t'(w_cnt[i]) >= cnt_word_t'(THRESH)) begin
                w_over = 1'b1;
            end
        end
    end

    // Readout FSM: capture on acceptance, present for one cycle, result held until the next response
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state    <= IDLE;
            r_valid    <= 1'b0;
            r_rd_cnt   <= '0;
            r_rd_stuck <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (rd_req_i) begin
                        r_state    <= RESP;
                        r_valid    <= 1'b1;
                        r_rd_cnt   <= w_sel_cnt;
                        r_rd_stuck <= w_sel_stuck;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    // Sticky irq: while low it follows the threshold level (so a set beats a same-cycle ack);
    // while high only an ack drops it, and the level re-arms it on the following cycle
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_irq <= 1'b0;
        end else if (r_irq) begin
            r_irq <= ~irq_ack_i;
        end else begin
            r_irq <= w_over;
        end
    end

    // A reset landing during the response cycle suppresses the strobe immediately
    assign rd_valid_o = r_valid & rst_n_i;
    assign rd_cnt_o   = r_rd_cnt;
    assign rd_stuck_o = r_rd_stuck;
    assign stuck_o    = w_stuck;
    assign irq_o      = r_irq;

endmodule

// File: tb/tb_hamming_seu_monitor.sv
// tb/tb_hamming_seu_monitor.sv - self-checking bench for hamming_seu_monitor
module tb_hamming_seu_monitor;

    localparam int N    = 5;
    localparam int CW   = 4;
    localparam int TH   = 4;
    localparam int SC   = 8;
    localparam int SELW = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    sec = '0;
    logic            rd_req = 1'b0;
    logic [SELW-1:0] rd_sel = '0;
    logic            rd_clr = 1'b0;
    logic            irq_ack = 1'b0;
    logic            rd_valid;
    logic [CW-1:0]   rd_cnt;
    logic            rd_stuck;
    logic [N-1:0]    stuck;
    logic            irq;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hamming_seu_monitor #(
        .NUM_SRC   (N),
        .CNT_W     (CW),
        .THRESH    (TH),
        .STUCK_CYC (SC)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .sec_i      (sec),
        .rd_req_i   (rd_req),
        .rd_sel_i   (rd_sel),
        .rd_clr_i   (rd_clr),
        .rd_valid_o (rd_valid),
        .rd_cnt_o   (rd_cnt),
        .rd_stuck_o (rd_stuck),
        .stuck_o    (stuck),
        .irq_o      (irq),
        .irq_ack_i  (irq_ack)
    );

    // Reference model: counts, stuck runs, readout and irq derived from the behavioural rules
    int           m_cnt  [N];
    int           m_run  [N];
    bit           m_prev [N];
    bit           m_pend [N];
    logic [N-1:0] m_stuckv = '0;
    bit           m_resp = 0;
    bit           m_valid = 0;
    int           m_rcnt = 0;
    bit           m_rstuck = 0;
    bit           m_irq = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_cnt[i] = 0; m_run[i] = 0; m_prev[i] = 0; m_pend[i] = 0;
            end
            m_stuckv = '0; m_resp = 0; m_valid = 0; m_rcnt = 0; m_rstuck = 0; m_irq = 0;
        end else begin
            bit acc;
            bit over;
            int s;
            acc  = !m_resp && rd_req;
            s    = int'(rd_sel);
            over = 0;
            for (int i = 0; i < N; i++) if (m_cnt[i] >= TH) over = 1;
            if (acc) begin
                m_rcnt   = (s < N) ? m_cnt[s] : 0;
                m_rstuck = (s < N) ? m_stuckv[s] : 1'b0;
            end
            m_valid = acc;
            m_resp  = acc;
            m_irq   = m_irq ? !irq_ack : over;
            for (int i = 0; i < N; i++) begin
                int c;
                c = m_cnt[i];
                if (m_pend[i]) c = (c + 1 > CMAX) ? CMAX : c + 1;
                if (acc && rd_clr && s == i) c = m_pend[i] ? 1 : 0;
                m_cnt[i]    = c;
                m_pend[i]   = sec[i] && !m_prev[i];
                m_prev[i]   = sec[i];
                m_run[i]    = sec[i] ? ((m_run[i] < SC) ? m_run[i] + 1 : SC) : 0;
                m_stuckv[i] = (m_run[i] == SC);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_in();
        rst_n = 1'b1; sec = '0; rd_req = 1'b0; rd_sel = '0; rd_clr = 1'b0; irq_ack = 1'b0;
    endtask

    task automatic pulses(input int src, input int n);
        for (int k = 0; k < n; k++) begin
            sec[src] = 1'b1; tick();
            sec[src] = 1'b0; tick();
        end
    endtask

    task automatic read(input int sel, input bit clr, input int exp_cnt, input string nm);
        rd_req = 1'b1; rd_sel = SELW'(sel); rd_clr = clr;
        tick();
        chk({nm, "_valid"}, rd_valid, 1);
        chk({nm, "_cnt"}, rd_cnt, exp_cnt);
        rd_req = 1'b0; rd_clr = 1'b0;
        tick();
    endtask

    typedef struct {
        logic            rst_n;
        logic [N-1:0]    sec;
        logic            req;
        logic [SELW-1:0] sel;
        logic            clr;
        logic            ack;
        logic            e_valid;
        logic [CW-1:0]   e_cnt;
        logic            e_stuck;
        logic [N-1:0]    e_stuckv;
        logic            e_irq;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [N-1:0] s, input logic q,
                                input logic [SELW-1:0] sl, input logic ev, input logic [CW-1:0] ec);
        vec_t v;
        v.rst_n = r; v.sec = s; v.req = q; v.sel = sl; v.clr = 1'b0; v.ack = 1'b0;
        v.e_valid = ev; v.e_cnt = ec; v.e_stuck = 1'b0; v.e_stuckv = '0; v.e_irq = 1'b0;
        return v;
    endfunction

    vec_t tbl [18];

    initial begin
        // Reset, three single-cycle pulses on source 2, then readouts of every source
        tbl[0]  = mk(0, 5'b00000, 0, 0, 0, 0);
        tbl[1]  = mk(0, 5'b00000, 0, 0, 0, 0);
        tbl[2]  = mk(1, 5'b00100, 0, 0, 0, 0);
        tbl[3]  = mk(1, 5'b00000, 0, 0, 0, 0);
        tbl[4]  = mk(1, 5'b00100, 0, 0, 0, 0);
        tbl[5]  = mk(1, 5'b00000, 0, 0, 0, 0);
        tbl[6]  = mk(1, 5'b00100, 0, 0, 0, 0);
        tbl[7]  = mk(1, 5'b00000, 0, 0, 0, 0);
        tbl[8]  = mk(1, 5'b00000, 1, 2, 1, 3);
        tbl[9]  = mk(1, 5'b00000, 0, 0, 0, 3);
        tbl[10] = mk(1, 5'b00000, 1, 0, 1, 0);
        tbl[11] = mk(1, 5'b00000, 0, 0, 0, 0);
        tbl[12] = mk(1, 5'b00000, 1, 1, 1, 0);
        tbl[13] = mk(1, 5'b00000, 0, 0, 0, 0);
        tbl[14] = mk(1, 5'b00000, 1, 6, 1, 0);
        tbl[15] = mk(1, 5'b00000, 0, 0, 0, 0);
        tbl[16] = mk(1, 5'b00000, 1, 2, 1, 3);
        tbl[17] = mk(1, 5'b00000, 1, 0, 0, 3);

        for (int k = 0; k < 18; k++) begin
            rst_n = tbl[k].rst_n; sec = tbl[k].sec; rd_req = tbl[k].req;
            rd_sel = tbl[k].sel; rd_clr = tbl[k].clr; irq_ack = tbl[k].ack;
            tick();
            chk($sformatf("tbl%0d_valid", k), rd_valid, tbl[k].e_valid);
            chk($sformatf("tbl%0d_cnt", k), rd_cnt, tbl[k].e_cnt);
            chk($sformatf("tbl%0d_stuck", k), rd_stuck, tbl[k].e_stuck);
            chk($sformatf("tbl%0d_stuckv", k), stuck, tbl[k].e_stuckv);
            chk($sformatf("tbl%0d_irq", k), irq, tbl[k].e_irq);
        end
        idle_in();
        tick();

        // Source 1 held high: one event, stuck after the 8th high sample, clears on the first low
        for (int n = 1; n <= 20; n++) begin
            sec[1] = 1'b1;
            tick();
            chk($sformatf("stuck_hold%0d", n), stuck[1], (n >= SC) ? 1 : 0);
        end
        sec[1] = 1'b0;
        tick();
        chk("stuck_fall", stuck[1], 0);
        read(1, 0, 1, "hold_cnt");

        // Threshold irq: asserts one cycle after the 4th count, ack dip, clear then ack keeps it low
        pulses(0, TH);
        chk("irq_before", irq, 0);
        tick();
        chk("irq_set", irq, 1);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        chk("irq_ack_dip", irq, 0);
        tick();
        chk("irq_reset", irq, 1);
        read(0, 1, TH, "irq_clr_read");
        chk("irq_sticky", irq, 1);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        chk("irq_acked", irq, 0);
        tick();
        chk("irq_stays0", irq, 0);
        tick();
        chk("irq_stays0b", irq, 0);

        // Saturation at 2^CW-1
        pulses(0, 20);
        read(0, 1, CMAX, "sat_cnt");

        // Clear with a coincident event: read returns the old value, counter keeps the event
        pulses(3, 5);
        sec[3] = 1'b1; tick();
        sec[3] = 1'b0;
        read(3, 1, 5, "clr_evt_read");
        read(3, 0, 1, "clr_evt_after");

        // Reset during the response cycle
        rd_req = 1'b1; rd_sel = 3'd2;
        tick();
        rd_req = 1'b0; rst_n = 1'b0;
        #1;
        chk("rst_abort_valid", rd_valid, 0);
        tick();
        chk("rst_valid", rd_valid, 0);
        chk("rst_cnt", rd_cnt, 0);
        chk("rst_stuck", rd_stuck, 0);
        chk("rst_stuckv", stuck, 0);
        chk("rst_irq", irq, 0);
        idle_in();
        tick();
        read(2, 0, 0, "rst_read2");
        read(3, 0, 0, "rst_read3");

        // Randomised traffic against the reference model
        for (int c = 0; c < 2000; c++) begin
            logic [N-1:0] nsec;
            nsec = sec;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 99) < ((i == 4) ? 8 : 30)) nsec[i] = ~nsec[i];
            end
            sec     = nsec;
            rst_n   = ($urandom_range(0, 199) != 0);
            rd_req  = ($urandom_range(0, 2) == 0);
            rd_sel  = SELW'($urandom_range(0, 7));
            rd_clr  = ($urandom_range(0, 3) == 0);
            irq_ack = ($urandom_range(0, 9) == 0);
            tick();
            chk("rnd_valid", rd_valid, m_valid & rst_n);
            chk("rnd_cnt", rd_cnt, m_rcnt);
            chk("rnd_stuck", rd_stuck, m_rstuck);
            chk("rnd_stuckv", stuck, m_stuckv);
            chk("rnd_irq", irq, m_irq);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/hamming_seu_monitor.md
# hamming_seu_monitor

Downstream companion of the Hamming-protected FSM state registers: collects the single-error-corrected flags (`sec_o`) from up to NUM_SRC `h3_correct_n_k` correctors, counts correction events per source with saturating counters, flags sources whose flag stays high (stuck bit), and exposes the counts through a one-request/one-response readout port with optional atomic clear. Sits between the FSM corrector instances and the slow-control register map; it provides the radiation-upset statistics for the FSM state registers.

## Interface
- NUM_SRC, 4, number of monitored correctors (1..16)
- CNT_W, 16, width of each event counter
- THRESH, 100, per-source count at or above which `irq_o` is raised
- STUCK_CYC, 8, consecutive cycles of `sec_i` high that mark a source stuck (>=2)

- clk_i  in  1  single clock; all logic on rising edge
- rst_n_i  in  1  reset, synchronous, active-low
- sec_i  in  NUM_SRC  per-source correction flag (bit i from corrector i)
- rd_req_i  in  1  readout request, one-cycle pulse
- rd_sel_i  in  $clog2(NUM_SRC) (min 1)  source index for the request
- rd_clr_i  in  1  with `rd_req_i`: clear the selected counter after reading
- rd_valid_o  out  1  readout response strobe
- rd_cnt_o  out  CNT_W  counter value of the selected source
- rd_stuck_o  out  1  stuck flag of the selected source
- stuck_o  out  NUM_SRC  live stuck flags
- irq_o  out  1  sticky threshold interrupt
- irq_ack_i  in  1  clears `irq_o`

## Operation
- Event: rising edge of `sec_i[i]` (registered previous value low, current high). A flag held high counts once.
- Counter i increments by 1 per event; saturates at 2^CNT_W-1 with no wrap.
- Stuck timer i: counts consecutive high cycles of `sec_i[i]`, saturating at STUCK_CYC; `stuck_o[i]`=1 while the timer equals STUCK_CYC. A low `sec_i[i]` zeroes the timer, and `stuck_o[i]` falls in the same registered update.
- Readout FSM, states IDLE and RESP:
  - IDLE, `rd_req_i`=1: capture the value of counter `rd_sel_i` and its stuck flag from the current cycle, before any same-cycle increment or clear; go to RESP.
  - RESP: `rd_valid_o`=1 for one cycle; return to IDLE. A `rd_req_i` in RESP is ignored (not queued).
  - An out-of-range `rd_sel_i` (>= NUM_SRC) returns count 0 and stuck 0. A `rd_clr_i` with an out-of-range select has no effect.
- Clear: `rd_clr_i` is honoured only with an accepted request. The counter is written to 0 in the acceptance cycle. If an event occurs in the same cycle, the counter becomes 1, and the read returns the pre-clear value.
- `irq_o` is set when any counter is >= THRESH after update. It stays set until `irq_ack_i`. On ack, `irq_o`=0 next cycle, and it is re-set on a later cycle if any counter is still >= THRESH. If set and ack happen in the same cycle, set wins.

## Timing
- Reset (`rst_n_i`=0 at a clock edge): all counters, timers and edge registers 0; `rd_valid_o`=0, `rd_cnt_o`=0, `rd_stuck_o`=0, `stuck_o`=0, `irq_o`=0; FSM to IDLE. Reset asserted while in RESP aborts the response, so no `rd_valid_o` is issued.
- Event to counter update: 2 cycles from the first high sample of `sec_i` (1 edge-detect register + 1 counter register).
- Request to `rd_valid_o`: 1 cycle. `rd_cnt_o` and `rd_stuck_o` hold their value until the next response.
- Maximum request rate: one every 2 cycles.
- `stuck_o[i]` asserts on the cycle after the STUCK_CYC-th consecutive high sample.
- `irq_o` asserts 1 cycle after the counter update that reaches THRESH.

## Structure
- Package `seu_monitor_pkg`:
  - `typedef enum logic {IDLE, RESP} rd_state_t`
  - count type parameterised via `localparam` helper
  - `function sat_inc` (saturating increment)
- Sub-module `seu_event_counter`: edge detect, saturating counter, stuck timer, synchronous clear input. Instantiated NUM_SRC times in a generate loop. The top holds the readout FSM, the select mux and the irq logic.

## Test plan
- Reset, then pulse `sec_i[2]` high for 1 cycle three times -> read sel=2 gives `rd_cnt_o`=3 one cycle after request; all other sources read 0.
- Hold `sec_i[1]` high for 20 cycles -> counter 1 = 1; `stuck_o[1]` rises after the 8th high sample; drop `sec_i[1]` -> `stuck_o[1]`=0 next update.
- CNT_W=4: 20 events on source 0 -> counter saturates at 15 and reads 15.
- Read sel=3 with `rd_clr_i`=1 in the same cycle as an event on source 3 (prior count 5) -> `rd_cnt_o`=5; a subsequent read returns 1.
- THRESH=4: 4 events on source 0 -> `irq_o`=1. Ack -> `irq_o`=0 for one cycle, then 1 again (count still >= 4). Clear counter, then ack -> `irq_o` stays 0.
- Assert `rst_n_i`=0 in the cycle after a request -> no `rd_valid_o`; all outputs 0; counters read 0 after reset.
